// File: rtl/mul_div_unit.sv
// Iterative unsigned multiply/divide unit feeding the register-file write port.
// Optional divider datapath enabled by defining MUL_DIV_UNIT_DIV_EN.
//
// state  | meaning
// S_IDLE | waiting for start; operands latched on accept
// S_BUSY | one shift-add or restoring-divide iteration per edge
// S_DONE | single-cycle write-back (suppressed for r0), then back to idle
module mul_div_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int REG_ADDR   = 5
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  start,
    input  logic [1:0]            op,
    input  logic [DATA_WIDTH-1:0] a_data,
    input  logic [DATA_WIDTH-1:0] b_data,
    input  logic [REG_ADDR-1:0]   rd_addr,
    output logic                  busy,
    output logic                  wb_en,
    output logic [REG_ADDR-1:0]   wb_addr,
    output logic [DATA_WIDTH-1:0] wb_data
);

    localparam int IDX_W = $clog2(DATA_WIDTH);
    localparam int CNT_W = IDX_W + 1;

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t                  state, state_next;
    logic [1:0]              op_q;
    logic [DATA_WIDTH-1:0]   a_q, b_q;
    logic [REG_ADDR-1:0]     rd_q, rd_sel;
    logic [CNT_W-1:0]        cnt, cnt_next;
    logic [2*DATA_WIDTH-1:0] acc, acc_next;
    logic [DATA_WIDTH:0]     mul_sum;
    logic [DATA_WIDTH-1:0]   result;
    logic                    load;
`ifdef MUL_DIV_UNIT_DIV_EN
    logic [DATA_WIDTH:0]     rem, rem_next;
    logic [DATA_WIDTH+1:0]   trial;
    logic [IDX_W-1:0]        msb_idx;
    logic                    a_bit;
`endif

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        acc_next   = acc;
        mul_sum    = '0;
        load       = 1'b0;
        result     = '0;
        rd_sel     = rd_q;
`ifdef MUL_DIV_UNIT_DIV_EN
        rem_next   = rem;
        trial      = '0;
        msb_idx    = '0;
        a_bit      = 1'b0;
`endif
        case (state)
            S_IDLE: begin
                rd_sel = rd_addr;
                if (start) begin
                    load     = 1'b1;
                    cnt_next = '0;
                    acc_next = '0;
`ifdef MUL_DIV_UNIT_DIV_EN
                    rem_next   = '0;
                    state_next = S_BUSY;
`else
                    // Without the divider, divide ops complete immediately with zero.
                    state_next = op[1] ? S_DONE : S_BUSY;
`endif
                end
            end
            S_BUSY: begin
                cnt_next = cnt + 1'b1;
`ifdef MUL_DIV_UNIT_DIV_EN
                if (op_q[1]) begin
                    // Restoring step; b=0 never borrows, giving all-ones quotient and rem=a.
                    msb_idx = IDX_W'(DATA_WIDTH - 1) - cnt[IDX_W-1:0];
                    a_bit   = a_q[msb_idx];
                    trial   = {rem, a_bit} - {2'b00, b_q};
                    if (!trial[DATA_WIDTH+1]) begin
                        rem_next = trial[DATA_WIDTH:0];
                    end else begin
                        rem_next = {rem[DATA_WIDTH-1:0], a_bit};
                    end
                    acc_next[DATA_WIDTH-1:0] = {acc[DATA_WIDTH-2:0], ~trial[DATA_WIDTH+1]};
                end else
`endif
                begin
                    // Right-shifting product: carry of the add lands in the top bit.
                    mul_sum  = {1'b0, acc[2*DATA_WIDTH-1:DATA_WIDTH]}
                             + (b_q[cnt[IDX_W-1:0]] ? {1'b0, a_q} : '0);
                    acc_next = {mul_sum, acc[DATA_WIDTH-1:1]};
                end
                if (cnt == CNT_W'(DATA_WIDTH - 1)) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase

        if (state == S_BUSY) begin
            case (op_q)
                2'b00:   result = acc_next[DATA_WIDTH-1:0];
                2'b01:   result = acc_next[2*DATA_WIDTH-1:DATA_WIDTH];
`ifdef MUL_DIV_UNIT_DIV_EN
                2'b10:   result = acc_next[DATA_WIDTH-1:0];
                2'b11:   result = rem_next[DATA_WIDTH-1:0];
`endif
                default: result = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state   <= S_IDLE;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            rd_q    <= '0;
            cnt     <= '0;
            acc     <= '0;
            busy    <= 1'b0;
            wb_en   <= 1'b0;
            wb_addr <= '0;
            wb_data <= '0;
`ifdef MUL_DIV_UNIT_DIV_EN
            rem     <= '0;
`endif
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            acc   <= acc_next;
`ifdef MUL_DIV_UNIT_DIV_EN
            rem   <= rem_next;
`endif
            if (load) begin
                op_q <= op;
                a_q  <= a_data;
                b_q  <= b_data;
                rd_q <= rd_addr;
            end
            busy <= (state_next != S_IDLE);
            if (state_next == S_DONE && state != S_DONE) begin
                wb_en   <= (rd_sel != '0);
                wb_addr <= rd_sel;
                wb_data <= result;
            end else begin
                wb_en   <= 1'b0;
                wb_addr <= '0;
                wb_data <= '0;
            end
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit; expectations track MUL_DIV_UNIT_DIV_EN.
module tb_mul_div_unit;

    logic        clk = 1'b0;
    logic        rstn;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a_data, b_data;
    logic [4:0]  rd_addr;
    logic        busy, wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;

    int total = 0;
    int bad   = 0;

    mul_div_unit #(.DATA_WIDTH(32), .REG_ADDR(5)) dut (
        .clk     (clk),
        .rstn    (rstn),
        .start   (start),
        .op      (op),
        .a_data  (a_data),
        .b_data  (b_data),
        .rd_addr (rd_addr),
        .busy    (busy),
        .wb_en   (wb_en),
        .wb_addr (wb_addr),
        .wb_data (wb_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic scramble_inputs();
        op      = 2'($urandom);
        a_data  = $urandom;
        b_data  = $urandom;
        rd_addr = 5'($urandom);
    endtask

    // Called at a negedge; start is asserted for one edge, then the window is observed.
    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd, input logic [31:0] exp_data,
                          input int exp_lat, input bit exp_wb, input logic [63:0] pulse_mask);
        int wb_cnt = 0;
        int wb_cyc = -1;
        int busy_cnt = 0;
        logic [4:0]  got_addr = '0;
        logic [31:0] got_data = '0;
        start = 1'b1; op = o; a_data = a; b_data = b; rd_addr = rd;
        @(posedge clk);
        #1;
        start = 1'b0;
        scramble_inputs();
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (busy) busy_cnt++;
            if (wb_en) begin
                wb_cnt++;
                wb_cyc   = k;
                got_addr = wb_addr;
                got_data = wb_data;
            end
            start = pulse_mask[k];
            if (pulse_mask[k]) scramble_inputs();
        end
        start = 1'b0;
        check({tag, ".wb_count"}, wb_cnt, exp_wb ? 1 : 0);
        check({tag, ".busy_cycles"}, busy_cnt, exp_lat);
        if (exp_wb) begin
            check({tag, ".wb_cycle"}, wb_cyc, exp_lat);
            check({tag, ".wb_addr"}, got_addr, rd);
            check({tag, ".wb_data"}, got_data, exp_data);
        end
    endtask

    task automatic run_div(input string tag, input logic [1:0] o, input logic [31:0] a,
                           input logic [31:0] b, input logic [4:0] rd, input logic [31:0] exp_data);
`ifdef MUL_DIV_UNIT_DIV_EN
        run_op(tag, o, a, b, rd, exp_data, 33, rd != 0, 64'd0);
`else
        run_op(tag, o, a, b, rd, 32'd0 & exp_data, 1, rd != 0, 64'd0);
`endif
    endtask

    initial begin
        int wb_seen;
        rstn = 1'b0; start = 1'b0; op = '0; a_data = '0; b_data = '0; rd_addr = '0;
        repeat (3) @(negedge clk);
        check("reset.busy", busy, 1'b0);
        check("reset.wb_en", wb_en, 1'b0);
        check("reset.wb_addr", wb_addr, 5'd0);
        check("reset.wb_data", wb_data, 32'd0);
        rstn = 1'b1;
        @(negedge clk);

        run_op("mulu_ffff", 2'b00, 32'h0000_FFFF, 32'h0001_0001, 5'd3, 32'hFFFF_FFFF, 33, 1'b1, 64'd0);
        run_op("mulhu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7, 32'hFFFF_FFFE, 33, 1'b1, 64'd0);
        run_op("mulu_max",  2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7, 32'h0000_0001, 33, 1'b1, 64'd0);
        run_op("mulu_x9",   2'b00, 32'h1234_5678, 32'd9, 5'd12, 32'hA3D7_0A38, 33, 1'b1, 64'd0);
        run_op("mulhu_pow", 2'b01, 32'h8000_0000, 32'd4, 5'd31, 32'h0000_0002, 33, 1'b1, 64'd0);

        run_div("divu_100_7",  2'b10, 32'd100, 32'd7, 5'd4, 32'd14);
        run_div("remu_100_7",  2'b11, 32'd100, 32'd7, 5'd5, 32'd2);
        run_div("divu_by0",    2'b10, 32'd5, 32'd0, 5'd6, 32'hFFFF_FFFF);
        run_div("remu_by0",    2'b11, 32'd5, 32'd0, 5'd8, 32'd5);
        run_div("divu_big",    2'b10, 32'hFFFF_FFFF, 32'h10, 5'd9, 32'h0FFF_FFFF);
        run_div("remu_big",    2'b11, 32'hFFFF_FFFF, 32'h10, 5'd10, 32'hF);

        // start pulses at cycles 5 and 32 of a running op and in its DONE cycle
        run_op("start_ignored", 2'b00, 32'd3, 32'd5, 5'd9, 32'd15, 33, 1'b1,
               (64'd1 << 5) | (64'd1 << 32) | (64'd1 << 33));
        run_op("rd_zero", 2'b00, 32'd3, 32'd5, 5'd0, 32'd15, 33, 1'b0, 64'd0);

        // asynchronous reset in the middle of an operation
        start = 1'b1; op = 2'b00; a_data = 32'd11; b_data = 32'd13; rd_addr = 5'd2;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (10) @(negedge clk);
        check("midrst.busy_before", busy, 1'b1);
        #2 rstn = 1'b0;
        #1;
        check("midrst.busy", busy, 1'b0);
        check("midrst.wb_en", wb_en, 1'b0);
        check("midrst.wb_addr", wb_addr, 5'd0);
        check("midrst.wb_data", wb_data, 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        wb_seen = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (wb_en || busy) wb_seen++;
        end
        check("midrst.quiet", wb_seen, 0);
        run_op("after_rst", 2'b00, 32'd11, 32'd13, 5'd2, 32'd143, 33, 1'b1, 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
